rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries (power of two).
REQ-002 SHALL have parameter MACHINE_WIDTH, default 2, allocate and commit slots per cycle.
REQ-003 SHALL have parameter WB_PORTS, default 2, completion ports (one per ALU).
REQ-004 SHALL have parameters AREG_W, default 5, and PREG_W, default 6, register address widths; TAG_W = log2(ROB_DEPTH).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  sync reset, active high.
REQ-006 SHALL have alloc_valid  in  MACHINE_WIDTH  per-slot allocate request from renaming.
REQ-007 SHALL have alloc_wen  in  MACHINE_WIDTH  per slot: instruction writes a register.
REQ-008 SHALL have alloc_areg  in  MACHINE_WIDTH*AREG_W, alloc_preg  in  MACHINE_WIDTH*PREG_W, and alloc_old_preg  in  MACHINE_WIDTH*PREG_W: per-slot destination mapping.
REQ-009 SHALL have alloc_ready  out  1  (ROB accepts a full group) and alloc_tag  out  MACHINE_WIDTH*TAG_W  (entry index per slot).
REQ-010 SHALL have wb_valid  in  WB_PORTS, wb_tag  in  WB_PORTS*TAG_W, wb_exc  in  WB_PORTS: completion from execute.
REQ-011 SHALL have commit_valid  out  MACHINE_WIDTH, plus commit_wen, commit_areg, commit_preg, commit_old_preg  out  per-slot widths as alloc: retirement to ARF/free list.
REQ-012 SHALL have flush  out  1  exception at head, pipeline squash.

Function
REQ-013 SHALL hold a circular buffer; head/tail pointers are TAG_W+1 bits (wrap bit), count = tail - head, 0..ROB_DEPTH.
REQ-014 SHALL drive alloc_ready = (count <= ROB_DEPTH - MACHINE_WIDTH) and not flush; combinational.
REQ-015 SHALL allocate all-or-nothing: when alloc_ready=1, valid slots take consecutive entries from tail in ascending slot order, compacted (slot1 alone gets tail).
REQ-016 SHALL drive alloc_tag combinationally from current tail with the REQ-015 compaction; value meaningless for invalid slots.
REQ-017 SHALL on allocation, at the next edge, set the entry valid, clear complete/exc, store wen/areg/preg/old_preg, advance tail by number allocated.
REQ-018 SHALL on wb_valid, at the next edge, set complete and OR in wb_exc for entry wb_tag; two ports to one tag are ORed; writes to an invalid entry are ignored.
REQ-019 SHALL drive commit_valid[0] = head entry valid & complete & !exc; commit_valid[i] = commit_valid[i-1] & entry head+i valid & complete & !exc; combinational, in order, no gaps.
REQ-020 SHALL at the edge invalidate committed entries and advance head by the number committed.
REQ-021 SHALL update count = count + n_alloc - n_commit when allocation and commit occur in the same cycle.
REQ-022 SHALL never commit an entry in the cycle it is allocated or written back (minimum alloc->commit latency 2 cycles: alloc edge, wb edge, commit next cycle).
REQ-023 SHALL drive flush=1 combinationally when the head entry is valid, complete and exc; commit_valid all 0 that cycle.
REQ-024 SHALL on flush, at the edge: clear all valid bits, head=tail=0, ignore same-cycle alloc and wb; flush is 1 for exactly one cycle.
REQ-025 SHALL report an exception on entry head+1 only once it reaches head (slot 0 commits, flush next cycle).
REQ-026 SHALL handle pointer wrap-around: full when count=ROB_DEPTH, empty when count=0, both distinguished by the wrap bit.

Reset
REQ-027 SHALL on reset clear all valid/complete/exc bits, head=tail=0; after reset alloc_ready=1, commit_valid=0, flush=0.
REQ-028 SHALL give reset priority over alloc, wb and flush in the same cycle.

Verification
REQ-029 SHALL pass: reset, alloc both slots (areg 3/4, preg 33/34) -> alloc_tag 0/1; wb tags 0,1 -> next cycle commit_valid=2'b11 with areg 3/4.
REQ-030 SHALL pass: fill to count=15 -> alloc_ready=0; commit one -> count 14, alloc_ready=1.
REQ-031 SHALL pass: wb tag 1 only -> commit_valid=0; then wb tag 0 -> both commit same cycle.
REQ-032 SHALL pass: wb tag 0 with exc=1 -> flush=1 one cycle, commit_valid=0, next cycle count=0, alloc_tag=0.
REQ-033 SHALL pass: 20 alloc/commit pairs -> tail wraps 15->0, tags sequential mod 16, no spurious full/empty.
REQ-034 SHALL pass: only alloc_valid[1]=1 -> receives tag=tail, tail+1; reset mid-fill -> count=0, commit_valid=0.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, records completion and
// exceptions from the execute ports, and retires up to MACHINE_WIDTH entries
// per cycle in order. An exception at the head squashes the whole buffer.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   alloc_valid/wen/areg/preg/old_preg  per-slot allocate request from rename
//   alloc_ready                      buffer can take a full group this cycle
//   alloc_tag                        entry index per slot (compacted from tail)
//   wb_valid/wb_tag/wb_exc           completion reports, one per execute port
//   commit_valid/wen/areg/preg/old_preg retirement to ARF / free list
//   flush                            head entry completed with an exception
module rob #(
    parameter int unsigned ROB_DEPTH     = 16,
    parameter int unsigned MACHINE_WIDTH = 2,
    parameter int unsigned WB_PORTS      = 2,
    parameter int unsigned AREG_W        = 5,
    parameter int unsigned PREG_W        = 6,
    parameter int unsigned TAG_W         = $clog2(ROB_DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [MACHINE_WIDTH-1:0]          alloc_valid,
    input  logic [MACHINE_WIDTH-1:0]          alloc_wen,
    input  logic [MACHINE_WIDTH*AREG_W-1:0]   alloc_areg,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]   alloc_preg,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]   alloc_old_preg,
    output logic                              alloc_ready,
    output logic [MACHINE_WIDTH*TAG_W-1:0]    alloc_tag,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]         wb_tag,
    input  logic [WB_PORTS-1:0]               wb_exc,
    output logic [MACHINE_WIDTH-1:0]          commit_valid,
    output logic [MACHINE_WIDTH-1:0]          commit_wen,
    output logic [MACHINE_WIDTH*AREG_W-1:0]   commit_areg,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   commit_preg,
    output logic [MACHINE_WIDTH*PREG_W-1:0]   commit_old_preg,
    output logic                              flush
);

    localparam int unsigned PTR_W = TAG_W + 1;

    typedef struct packed {
        logic              wen;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
    } entry_t;

    entry_t               ent_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] valid_q, complete_q, exc_q;
    logic [ROB_DEPTH-1:0] valid_d, complete_d, exc_d;
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [PTR_W-1:0]     count;
    logic [PTR_W-1:0]     alloc_off;
    logic [PTR_W-1:0]     n_alloc, n_commit;
    logic [TAG_W-1:0]     head_idx;
    logic [TAG_W-1:0]     c_idx;
    logic [TAG_W-1:0]     wb_idx;
    logic                 c_run;

    // Occupancy, head exception detection and allocation gating.
    always_comb begin
        count       = tail_q - head_q;
        head_idx    = head_q[TAG_W-1:0];
        flush       = valid_q[head_idx] & complete_q[head_idx] & exc_q[head_idx];
        alloc_ready = (count <= PTR_W'(ROB_DEPTH - MACHINE_WIDTH)) && !flush;
    end

    // Valid slots take consecutive entries from tail, skipping invalid slots.
    always_comb begin
        alloc_tag = '0;
        alloc_off = '0;
        for (int i = 0; i < int'(MACHINE_WIDTH); i++) begin
            alloc_tag[i*TAG_W +: TAG_W] = tail_q[TAG_W-1:0] + alloc_off[TAG_W-1:0];
            alloc_off = alloc_off + PTR_W'(alloc_valid[i]);
        end
        n_alloc = alloc_ready ? alloc_off : '0;
    end

    // In-order retirement: a slot commits only if every older slot commits.
    always_comb begin
        commit_valid    = '0;
        commit_wen      = '0;
        commit_areg     = '0;
        commit_preg     = '0;
        commit_old_preg = '0;
        n_commit        = '0;
        c_run           = 1'b1;
        c_idx           = '0;
        for (int i = 0; i < int'(MACHINE_WIDTH); i++) begin
            c_idx = head_idx + TAG_W'(i);
            c_run = c_run & valid_q[c_idx] & complete_q[c_idx] & ~exc_q[c_idx];
            commit_valid[i]                    = c_run;
            commit_wen[i]                      = ent_q[c_idx].wen;
            commit_areg[i*AREG_W +: AREG_W]    = ent_q[c_idx].areg;
            commit_preg[i*PREG_W +: PREG_W]    = ent_q[c_idx].preg;
            commit_old_preg[i*PREG_W +: PREG_W] = ent_q[c_idx].old_preg;
            n_commit = n_commit + PTR_W'(c_run);
        end
    end

    // Next entry status: writeback, then allocation, then retirement.
    // Writeback ports are accumulated so two ports hitting one tag OR their exc.
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        exc_d      = exc_q;
        wb_idx     = '0;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int p = 0; p < int'(WB_PORTS); p++) begin
                wb_idx = wb_tag[p*TAG_W +: TAG_W];
                if (wb_valid[p] && valid_q[wb_idx]) begin
                    complete_d[wb_idx] = 1'b1;
                    exc_d[wb_idx]      = exc_d[wb_idx] | wb_exc[p];
                end
            end
            for (int i = 0; i < int'(MACHINE_WIDTH); i++) begin
                if (alloc_ready && alloc_valid[i]) begin
                    valid_d[alloc_tag[i*TAG_W +: TAG_W]]    = 1'b1;
                    complete_d[alloc_tag[i*TAG_W +: TAG_W]] = 1'b0;
                    exc_d[alloc_tag[i*TAG_W +: TAG_W]]      = 1'b0;
                end
            end
            for (int i = 0; i < int'(MACHINE_WIDTH); i++) begin
                if (commit_valid[i]) begin
                    valid_d[head_idx + TAG_W'(i)] = 1'b0;
                end
            end
        end
    end

    // Status bits and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            exc_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            exc_q      <= exc_d;
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                head_q <= head_q + n_commit;
                tail_q <= tail_q + n_alloc;
            end
        end
    end

    // Entry payload; only meaningful while the entry is valid, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(MACHINE_WIDTH); i++) begin
            if (alloc_ready && alloc_valid[i]) begin
                ent_q[alloc_tag[i*TAG_W +: TAG_W]] <= {alloc_wen[i],
                                                       alloc_areg[i*AREG_W +: AREG_W],
                                                       alloc_preg[i*PREG_W +: PREG_W],
                                                       alloc_old_preg[i*PREG_W +: PREG_W]};
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a reference model of entry status and pointers
// predicts alloc_ready / flush / commit_valid / alloc_tag each cycle, and a
// scoreboard queue of allocated payloads is popped on every expected commit.
module tb_rob;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MW    = 2;
    localparam int unsigned WBP   = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned PW    = 6;
    localparam int unsigned TW    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [MW-1:0]     alloc_valid, alloc_wen;
    logic [MW*AW-1:0]  alloc_areg;
    logic [MW*PW-1:0]  alloc_preg, alloc_old_preg;
    logic              alloc_ready;
    logic [MW*TW-1:0]  alloc_tag;
    logic [WBP-1:0]    wb_valid, wb_exc;
    logic [WBP*TW-1:0] wb_tag;
    logic [MW-1:0]     commit_valid, commit_wen;
    logic [MW*AW-1:0]  commit_areg;
    logic [MW*PW-1:0]  commit_preg, commit_old_preg;
    logic              flush;

    rob #(
        .ROB_DEPTH(DEPTH), .MACHINE_WIDTH(MW), .WB_PORTS(WBP),
        .AREG_W(AW), .PREG_W(PW), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_wen(alloc_wen),
        .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
        .alloc_old_preg(alloc_old_preg),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exc(wb_exc),
        .commit_valid(commit_valid), .commit_wen(commit_wen),
        .commit_areg(commit_areg), .commit_preg(commit_preg),
        .commit_old_preg(commit_old_preg), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wen;
        logic [AW-1:0] areg;
        logic [PW-1:0] preg;
        logic [PW-1:0] old_preg;
    } ent_t;

    ent_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_head, m_tail;
    logic m_valid [DEPTH];
    logic m_comp  [DEPTH];
    logic m_exc   [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = '0; alloc_wen = '0; alloc_areg = '0;
        alloc_preg = '0; alloc_old_preg = '0;
        wb_valid = '0; wb_tag = '0; wb_exc = '0;
    endtask

    task automatic set_alloc(input int s, input logic w, input int a, input int p, input int o);
        alloc_valid[s]          = 1'b1;
        alloc_wen[s]            = w;
        alloc_areg[s*AW +: AW]  = AW'(a);
        alloc_preg[s*PW +: PW]  = PW'(p);
        alloc_old_preg[s*PW +: PW] = PW'(o);
    endtask

    task automatic set_wb(input int p, input int t, input logic e);
        wb_valid[p]         = 1'b1;
        wb_tag[p*TW +: TW]  = TW'(t % DEPTH);
        wb_exc[p]           = e;
    endtask

    task automatic model_clear();
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_comp[i] = 1'b0; m_exc[i] = 1'b0;
        end
        sbq.delete();
    endtask

    // Reset asserted together with alloc and wb traffic; reset must win.
    task automatic do_reset();
        set_alloc(0, 1'b1, 9, 9, 9);
        set_alloc(1, 1'b1, 9, 9, 9);
        set_wb(0, 0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic cycle();
        int h, h1, cnt, k, idx;
        logic ef, er;
        logic [1:0] ecv;
        ent_t e;
        #1;
        cnt = (m_tail - m_head) & 31;
        h   = m_head % DEPTH;
        h1  = (m_head + 1) % DEPTH;
        ef  = m_valid[h] & m_comp[h] & m_exc[h];
        ecv[0] = m_valid[h] & m_comp[h] & ~m_exc[h];
        ecv[1] = ecv[0] & m_valid[h1] & m_comp[h1] & ~m_exc[h1];
        er  = (cnt <= DEPTH - MW) && !ef;
        check("flush", 32'(flush), 32'(ef));
        check("commit_valid", 32'(commit_valid), 32'(ecv));
        check("alloc_ready", 32'(alloc_ready), 32'(er));
        for (int s = 0; s < MW; s++) begin
            if (ecv[s]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow: observed commit on slot %0d expected none", s);
                end else begin
                    e = sbq.pop_front();
                    check("commit_wen", 32'(commit_wen[s]), 32'(e.wen));
                    check("commit_areg", 32'(commit_areg[s*AW +: AW]), 32'(e.areg));
                    check("commit_preg", 32'(commit_preg[s*PW +: PW]), 32'(e.preg));
                    check("commit_old_preg", 32'(commit_old_preg[s*PW +: PW]), 32'(e.old_preg));
                end
            end
        end
        k = 0;
        if (er) begin
            for (int s = 0; s < MW; s++) begin
                if (alloc_valid[s]) begin
                    check("alloc_tag", 32'(alloc_tag[s*TW +: TW]), 32'((m_tail + k) % DEPTH));
                    e.wen      = alloc_wen[s];
                    e.areg     = alloc_areg[s*AW +: AW];
                    e.preg     = alloc_preg[s*PW +: PW];
                    e.old_preg = alloc_old_preg[s*PW +: PW];
                    sbq.push_back(e);
                    k++;
                end
            end
        end
        @(posedge clk);
        if (ef) begin
            model_clear();
        end else begin
            for (int p = 0; p < WBP; p++) begin
                idx = int'(wb_tag[p*TW +: TW]);
                if (wb_valid[p] && m_valid[idx]) begin
                    m_comp[idx] = 1'b1;
                    m_exc[idx]  = m_exc[idx] | wb_exc[p];
                end
            end
            for (int j = 0; j < k; j++) begin
                idx = (m_tail + j) % DEPTH;
                m_valid[idx] = 1'b1; m_comp[idx] = 1'b0; m_exc[idx] = 1'b0;
            end
            for (int s = 0; s < MW; s++) begin
                if (ecv[s]) begin
                    m_valid[(m_head + s) % DEPTH] = 1'b0;
                end
            end
            m_head = (m_head + int'(ecv[0]) + int'(ecv[1])) % 32;
            m_tail = (m_tail + k) % 32;
        end
        #1;
        idle_inputs();
    endtask

    initial begin
        int w;
        reset = 1'b0;
        idle_inputs();
        do_reset();

        // Reset state.
        #1;
        check("reset_ready", 32'(alloc_ready), 32'd1);
        check("reset_commit_valid", 32'(commit_valid), 32'd0);
        check("reset_flush", 32'(flush), 32'd0);
        cycle();

        // Allocate a pair, complete both, retire both together.
        set_alloc(0, 1'b1, 3, 33, 1);
        set_alloc(1, 1'b1, 4, 34, 2);
        #1;
        check("pair_tag0", 32'(alloc_tag[0 +: TW]), 32'd0);
        check("pair_tag1", 32'(alloc_tag[TW +: TW]), 32'd1);
        cycle();
        set_wb(0, 0, 1'b0);
        set_wb(1, 1, 1'b0);
        cycle();
        #1;
        check("pair_commit_valid", 32'(commit_valid), 32'd3);
        check("pair_areg0", 32'(commit_areg[0 +: AW]), 32'd3);
        check("pair_areg1", 32'(commit_areg[AW +: AW]), 32'd4);
        cycle();

        // Younger completes first: nothing retires until the older completes.
        set_alloc(0, 1'b0, 5, 35, 3);
        set_alloc(1, 1'b1, 6, 36, 4);
        cycle();
        set_wb(0, 3, 1'b0);
        cycle();
        cycle();
        set_wb(1, 2, 1'b0);
        cycle();
        #1;
        check("ooo_commit_both", 32'(commit_valid), 32'd3);
        cycle();

        // Only slot 1 valid: compacted onto tail.
        set_alloc(1, 1'b1, 7, 37, 5);
        #1;
        check("slot1_alone_tag", 32'(alloc_tag[TW +: TW]), 32'd4);
        cycle();
        set_wb(0, 4, 1'b0);
        cycle();
        cycle();

        // Fill to 15, blocked allocation, retire one, then fill to full (16).
        for (int i = 0; i < 7; i++) begin
            set_alloc(0, 1'b1, i, 40 + i, i);
            set_alloc(1, 1'b0, i + 8, 50 + i, i + 1);
            cycle();
        end
        set_alloc(0, 1'b1, 20, 60, 21);
        cycle();
        #1;
        check("count15_ready", 32'(alloc_ready), 32'd0);
        set_alloc(0, 1'b1, 30, 30, 30);
        set_alloc(1, 1'b1, 31, 31, 31);
        cycle();
        set_wb(0, m_head, 1'b0);
        cycle();
        cycle();
        #1;
        check("count14_ready", 32'(alloc_ready), 32'd1);
        set_alloc(0, 1'b1, 22, 62, 23);
        set_alloc(1, 1'b1, 24, 63, 25);
        cycle();
        #1;
        check("full_ready", 32'(alloc_ready), 32'd0);
        w = m_head;
        for (int i = 0; i < 8; i++) begin
            set_wb(0, w, 1'b0);
            set_wb(1, w + 1, 1'b0);
            w += 2;
            cycle();
        end
        cycle();
        cycle();
        #1;
        check("drained_ready", 32'(alloc_ready), 32'd1);
        check("drained_commit_valid", 32'(commit_valid), 32'd0);

        // Twenty back-to-back pairs: tags wrap through 15 -> 0.
        for (int i = 0; i < 20; i++) begin
            set_alloc(0, i[0], i, i + 1, i + 2);
            set_alloc(1, ~i[0], i + 3, i + 4, i + 5);
            cycle();
            set_wb(0, (m_tail - 2) % DEPTH, 1'b0);
            set_wb(1, (m_tail - 1) % DEPTH, 1'b0);
            cycle();
        end
        cycle();
        cycle();

        // Reset while partly full.
        for (int i = 0; i < 3; i++) begin
            set_alloc(0, 1'b1, 1, 1, 1);
            set_alloc(1, 1'b1, 2, 2, 2);
            cycle();
        end
        do_reset();
        #1;
        check("midfill_reset_ready", 32'(alloc_ready), 32'd1);
        check("midfill_reset_cv", 32'(commit_valid), 32'd0);
        cycle();

        // Exception at head: one-cycle flush, same-cycle traffic ignored.
        set_alloc(0, 1'b1, 10, 11, 12);
        set_alloc(1, 1'b1, 13, 14, 15);
        cycle();
        set_wb(0, 0, 1'b1);
        set_wb(1, 1, 1'b0);
        cycle();
        set_alloc(0, 1'b1, 16, 17, 18);
        set_alloc(1, 1'b1, 19, 20, 21);
        #1;
        check("exc_flush", 32'(flush), 32'd1);
        check("exc_commit_valid", 32'(commit_valid), 32'd0);
        cycle();
        set_alloc(0, 1'b1, 25, 26, 27);
        #1;
        check("post_flush_flush", 32'(flush), 32'd0);
        check("post_flush_tag", 32'(alloc_tag[0 +: TW]), 32'd0);
        cycle();
        set_wb(0, 0, 1'b0);
        cycle();
        cycle();

        // Exception on head+1: slot 0 retires first, flush the cycle after.
        set_alloc(0, 1'b1, 8, 40, 41);
        set_alloc(1, 1'b1, 9, 42, 43);
        cycle();
        set_wb(0, m_head, 1'b0);
        set_wb(1, m_head + 1, 1'b1);
        cycle();
        #1;
        check("exc1_slot0_commit", 32'(commit_valid), 32'd1);
        check("exc1_no_flush_yet", 32'(flush), 32'd0);
        cycle();
        #1;
        check("exc1_flush", 32'(flush), 32'd1);
        cycle();

        // Writeback to a not-yet-valid entry is dropped.
        set_alloc(0, 1'b1, 11, 44, 45);
        set_wb(0, m_tail, 1'b0);
        cycle();
        cycle();
        #1;
        check("stale_wb_ignored", 32'(commit_valid), 32'd0);
        // Both ports to one tag, exc on one of them: exc must stick.
        set_wb(0, m_head, 1'b0);
        set_wb(1, m_head, 1'b1);
        cycle();
        #1;
        check("or_exc_flush", 32'(flush), 32'd1);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
